// File: rtl/mux16_8_arb.sv
// -----------------------------------------------------------------------------
// mux16_8_arb -- 8-to-1 arbitrated merge onto a single registered output.
//
// Eight source channels compete for one output slot. Each cycle the output
// register can accept a word (load_en = !out_valid || out_ready). When it can,
// one valid channel is granted, its word is captured into the output register,
// and its channel index is reported on out_sel. Latency is one cycle. With
// out_ready held high, the block sustains one word per cycle.
//
// Arbitration:
//   default build : round-robin. The search starts one past the last granted
//                   channel and wraps from 7 to 0. After reset, ptr = 7, so
//                   channel 0 has first priority.
//   MUX16_8_ARB_FIXED_PRI_EN defined : fixed priority. The lowest-index valid
//                   channel always wins, and no pointer state exists.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_data   in   [8*WIDTH] channel k at bits [k*WIDTH +: WIDTH]
//   in_valid  in   [8]  per-channel word valid
//   in_ready  out  [8]  one-hot accept for the granted channel, or zero
//   out_data  out  [WIDTH] registered merged word
//   out_sel   out  [3]  source channel of out_data
//   out_valid out  out_data/out_sel are valid
//   out_ready in   downstream accept
// -----------------------------------------------------------------------------

// Per-channel data gate. A channel passes its word only while granted, so the
// merge is a plain OR across the channels.
module mux16_8_arb_lane #(
    parameter int WIDTH = 16
) (
    input  logic             gnt_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);
    assign data_o = data_i & {WIDTH{gnt_i}};
endmodule

module mux16_8_arb #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [8*WIDTH-1:0] in_data,
    input  logic [7:0]         in_valid,
    output logic [7:0]         in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_sel,
    output logic               out_valid,
    input  logic               out_ready
);
    localparam int NUM_LANES = 8;

    // Output register stage
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [2:0]       out_sel_q,   out_sel_d;

    // Arbitration results
    logic                                load_en;
    logic                                gnt_any;
    logic [2:0]                          gnt_idx;
    logic [NUM_LANES-1:0]                gnt_oh;
    logic [NUM_LANES-1:0][WIDTH-1:0]     lane_data;
    logic [WIDTH-1:0]                    sel_data;

    assign load_en = !out_valid_q || out_ready;

`ifdef MUX16_8_ARB_FIXED_PRI_EN
    // Fixed priority: scan from the top down, so the lowest valid index
    // is the last one assigned and wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                gnt_any = 1'b1;
                gnt_idx = 3'(i);
            end
        end
    end
`else
    // Index of the most recently granted channel. It resets to 7 so the
    // first search begins at channel 0.
    logic [2:0] ptr_q, ptr_d;

    // Round robin: candidate offsets run 8 down to 1 from ptr. The smallest
    // offset (nearest channel after ptr) is assigned last and wins. Offset 8
    // wraps to ptr itself, so the last winner has the lowest priority.
    always_comb begin
        logic [2:0] cand;
        cand    = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NUM_LANES; i >= 1; i--) begin
            cand = ptr_q + i[2:0];
            if (in_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (load_en && gnt_any)
            ptr_d = gnt_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_q <= 3'd7;
        else
            ptr_q <= ptr_d;
    end
`endif

    assign gnt_oh = gnt_any ? (NUM_LANES'(1) << gnt_idx) : '0;

    // in_ready is gated with rst_n. While reset holds out_valid low,
    // load_en is 1, and without the gate a grant would leak out.
    assign in_ready = (load_en && rst_n) ? gnt_oh : '0;

    // Data select: gate each channel by its grant bit, then OR the results.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        mux16_8_arb_lane #(.WIDTH(WIDTH)) u_lane (
            .gnt_i  (gnt_oh[k]),
            .data_i (in_data[k*WIDTH +: WIDTH]),
            .data_o (lane_data[k])
        );
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_LANES; k++)
            sel_data = sel_data | lane_data[k];
    end

    // Next state of the output register. With no grant, only out_valid
    // drops. The stale word and select are kept because nothing reads them.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load_en) begin
            out_valid_d = gnt_any;
            if (gnt_any) begin
                out_data_d = sel_data;
                out_sel_d  = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux16_8_arb.sv
module tb_mux16_8_arb;
    localparam int WIDTH = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_valid;
    logic [7:0]         in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_sel;
    logic               out_valid;
    logic               out_ready;

    int errors = 0;
    int checks = 0;
    int acc_beats = 0;   // source handshakes seen
    int del_beats = 0;   // output handshakes seen

    mux16_8_arb #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_ramp();
        for (int k = 0; k < 8; k++) in_data[k*WIDTH +: WIDTH] = 16'h1000 + 16'(k);
    endtask

    // Apply inputs, sample in_ready combinationally, then advance one edge.
    // The task also counts the handshakes seen on both sides.
    task automatic step(input logic [7:0] iv, input logic ordy, output logic [7:0] ir_seen);
        in_valid  = iv;
        out_ready = ordy;
        #1;
        ir_seen = in_ready;
        if ((in_ready & in_valid) != 8'h00) acc_beats++;
        if (out_valid && out_ready) del_beats++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 8'h00;
        out_ready = 1'b0;
        set_ramp();
        @(posedge clk);
        #1;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        #1;
        chk("rst in_ready",  32'(in_ready),  32'h0);
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst out_data",  32'(out_data),  32'h0);
        chk("rst out_sel",   32'(out_sel),   32'h0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 8'h00;
        out_ready = 1'b0;
    endtask

    // Behavioural model: grant by searching the channels in priority order
    function automatic int model_grant(input logic [7:0] iv, input int ptr);
`ifdef MUX16_8_ARB_FIXED_PRI_EN
        for (int c = 0; c < 8; c++) if (iv[c]) return c;
`else
        for (int d = 1; d <= 8; d++) if (iv[(ptr + d) % 8]) return (ptr + d) % 8;
`endif
        return -1;
    endfunction

    typedef struct {
        logic [7:0]  iv;
        logic        ordy;
        logic [7:0]  ir;
        logic        ov;
        logic        chk_d;
        logic [2:0]  sel;
        logic [15:0] dat;
    } vec_t;

    initial begin
        vec_t       tbl[10];
        logic [7:0] ir;
        int         exp_k;

        // Single-channel and wrap patterns give the same grant in both builds
        tbl[0] = '{8'h01, 1'b1, 8'h01, 1'b1, 1'b1, 3'd0, 16'h1000};
        tbl[1] = '{8'h04, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 16'h1000};
        tbl[2] = '{8'h04, 1'b1, 8'h04, 1'b1, 1'b1, 3'd2, 16'h1002};
        tbl[3] = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 16'h0000};
        tbl[4] = '{8'h80, 1'b0, 8'h80, 1'b1, 1'b1, 3'd7, 16'h1007};
        tbl[5] = '{8'h81, 1'b1, 8'h01, 1'b1, 1'b1, 3'd0, 16'h1000};
        tbl[6] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 16'h1000};
        tbl[7] = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 16'h0000};
        tbl[8] = '{8'h20, 1'b1, 8'h20, 1'b1, 1'b1, 3'd5, 16'h1005};
        tbl[9] = '{8'h10, 1'b1, 8'h10, 1'b1, 1'b1, 3'd4, 16'h1004};

        // Channel 0 only, right after reset
        do_reset();
        in_data[0 +: WIDTH] = 16'hA5A5;
        step(8'h01, 1'b1, ir);
        chk("first in_ready",  32'(ir),        32'h01);
        chk("first out_valid", 32'(out_valid), 32'h1);
        chk("first out_data",  32'(out_data),  32'hA5A5);
        chk("first out_sel",   32'(out_sel),   32'h0);

        // Table vectors
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].iv, tbl[i].ordy, ir);
            chk($sformatf("tbl%0d in_ready", i),  32'(ir),        32'(tbl[i].ir));
            chk($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            if (tbl[i].chk_d) begin
                chk($sformatf("tbl%0d out_sel", i),  32'(out_sel),  32'(tbl[i].sel));
                chk($sformatf("tbl%0d out_data", i), 32'(out_data), 32'(tbl[i].dat));
            end
        end

        // All channels valid, out_ready held high
        do_reset();
        for (int j = 0; j < 9; j++) begin
            step(8'hFF, 1'b1, ir);
`ifdef MUX16_8_ARB_FIXED_PRI_EN
            exp_k = 0;
`else
            exp_k = j % 8;
`endif
            chk($sformatf("all%0d in_ready", j), 32'(ir),       32'(8'h01 << exp_k));
            chk($sformatf("all%0d out_sel", j),  32'(out_sel),  32'(exp_k));
            chk($sformatf("all%0d out_data", j), 32'(out_data), 32'h1000 + 32'(exp_k));
        end

        // Stall with channel 3 held, then release
        do_reset();
        step(8'h08, 1'b1, ir);
        chk("stall load sel", 32'(out_sel), 32'h3);
        for (int j = 0; j < 4; j++) begin
            step(8'hFF, 1'b0, ir);
            chk($sformatf("stall%0d in_ready", j),  32'(ir),        32'h00);
            chk($sformatf("stall%0d out_valid", j), 32'(out_valid), 32'h1);
            chk($sformatf("stall%0d out_sel", j),   32'(out_sel),   32'h3);
            chk($sformatf("stall%0d out_data", j),  32'(out_data),  32'h1003);
        end
`ifdef MUX16_8_ARB_FIXED_PRI_EN
        exp_k = 0;
`else
        exp_k = 4;
`endif
        step(8'hFF, 1'b1, ir);
        chk("release in_ready", 32'(ir),      32'(8'h01 << exp_k));
        chk("release out_sel",  32'(out_sel), 32'(exp_k));

        // Assert reset between edges while an output word is held
        step(8'hFF, 1'b0, ir);
        chk("pre-arst out_valid", 32'(out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", 32'(out_valid), 32'h0);
        chk("arst out_data",  32'(out_data),  32'h0);
        chk("arst in_ready",  32'(in_ready),  32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(8'hFF, 1'b1, ir);
        chk("post-arst in_ready", 32'(ir),      32'h01);
        chk("post-arst out_sel",  32'(out_sel), 32'h0);

        // Random stimulus checked against the model
        do_reset();
        acc_beats = 0;
        del_beats = 0;
        begin
            int         mptr = 7;
            bit         mov = 0;
            int         msel = 0;
            logic [15:0] mdat = '0;
            logic [7:0] iv;
            logic       ordy;
            int         g;
            bit         load;
            for (int n = 0; n < 400; n++) begin
                for (int k = 0; k < 8; k++) in_data[k*WIDTH +: WIDTH] = 16'($urandom);
                iv   = 8'($urandom) & 8'($urandom);
                ordy = ($urandom_range(0, 3) != 0);
                load = !mov || ordy;
                g    = model_grant(iv, mptr);
                step(iv, ordy, ir);
                chk($sformatf("rnd%0d in_ready", n), 32'(ir),
                    (load && g >= 0) ? (32'h1 << g) : 32'h0);
                if (load) begin
                    if (g >= 0) begin
                        mov  = 1;
                        msel = g;
                        mdat = in_data[g*WIDTH +: WIDTH];
                        mptr = g;
                    end else begin
                        mov = 0;
                    end
                end
                chk($sformatf("rnd%0d out_valid", n), 32'(out_valid), 32'(mov));
                if (mov) begin
                    chk($sformatf("rnd%0d out_sel", n),  32'(out_sel),  32'(msel));
                    chk($sformatf("rnd%0d out_data", n), 32'(out_data), 32'(mdat));
                end
            end
        end
        // Every accepted word is either delivered or still held in the output
        chk("beat conservation", 32'(del_beats + (out_valid ? 1 : 0)), 32'(acc_beats));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
